// File: rtl/fp16_normalize_round_if.sv
// Handshake bundle between the add/sub front end, this back end and the
// result consumer. The slave modport is the normalizer's view of it.
interface fp16_normalize_round_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sign;
  logic [EXP_W-1:0]          in_exp;
  logic [FRAC_W+3:0]         in_mant;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXP_W+FRAC_W:0]     out_result;
  logic                      out_overflow;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow
  );

  // Normalizer side.
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow
  );
endinterface

// File: rtl/fp16_normalize_round.sv
// Back end of the binary16 add/sub datapath: iterative one-bit-per-cycle
// normalizer, a single round-to-nearest-even step, then overflow/subnormal
// handling and packing. One operation in flight at a time.
module fp16_normalize_round #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic clk,
  input  logic reset,
  fp16_normalize_round_if.slave bus
);
  // Mantissa layout: {carry, hidden, frac[FRAC_W-1:0], guard, sticky}
  localparam int M_W   = FRAC_W + 4;
  localparam int E_W   = EXP_W + 1;   // one spare bit to catch overflow
  localparam int R_W   = EXP_W + FRAC_W + 1;
  localparam int CARRY = M_W - 1;
  localparam int HID   = M_W - 2;
  localparam logic [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [E_W-1:0]     exp_q, exp_d;
  logic [M_W-1:0]     mant_q, mant_d;
  logic [R_W-1:0]     result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               round_inc;
  logic [FRAC_W+1:0]  round_sum;   // {carry, hidden, frac} after increment

  // Ready is decoded from state so it rises on the first cycle after reset.
  assign bus.in_ready     = (state_q == IDLE) && !reset;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = result_q;
  assign bus.out_overflow = ovf_q;

  // Next-state and datapath: exactly one normalize/round/pack action per cycle.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    round_inc   = mant_q[1] && (mant_q[0] || mant_q[2]);
    round_sum   = mant_q[M_W-1:2] + {{(FRAC_W+1){1'b0}}, round_inc};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sign;
          exp_d   = (bus.in_exp == '0) ? E_W'(1) : {1'b0, bus.in_exp};
          mant_d  = bus.in_mant;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          // True zero: always +0; packing with hidden=0 yields exp field 0.
          sign_d  = 1'b0;
          exp_d   = '0;
          state_d = PACK;
        end else if (mant_q[CARRY]) begin
          mant_d = {1'b0, mant_q[M_W-1:3], mant_q[2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + E_W'(1);
        end else if (!mant_q[HID] && (exp_q > E_W'(1))) begin
          mant_d = {mant_q[M_W-2:0], mant_q[0]};
          exp_d  = exp_q - E_W'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        // A rounding carry renormalizes by one; a subnormal that rounds up to
        // hidden=1 picks up exp field 1 naturally at pack time (exp_q is 1).
        if (round_sum[FRAC_W+1]) begin
          mant_d = {1'b0, round_sum[FRAC_W+1:1], 2'b00};
          exp_d  = exp_q + E_W'(1);
        end else begin
          mant_d = {round_sum, 2'b00};
        end
        state_d = PACK;
      end
      PACK: begin
        if (exp_q >= EXP_MAX) begin
          result_d = {sign_q, EXP_MAX[EXP_W-1:0], {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, (mant_q[HID] ? exp_q[EXP_W-1:0] : {EXP_W{1'b0}}),
                      mant_q[FRAC_W+1:2]};
          ovf_d    = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_fp16_normalize_round.sv
// Directed bench for fp16_normalize_round: hand-computed results, latency,
// overflow flag, output hold under backpressure and reset mid-operation.
module tb_fp16_normalize_round;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_failed = 0;

  always #5 clk = ~clk;

  fp16_normalize_round_if #(.EXP_W(5), .FRAC_W(10)) bus ();

  fp16_normalize_round #(.EXP_W(5), .FRAC_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Issue one op, measure accept-edge to out_valid latency, check and drain.
  task automatic run_op(input string tag, input logic s, input logic [4:0] e,
                        input logic [13:0] m, input logic [15:0] want_res,
                        input logic want_ovf, input int want_lat);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 50) begin
      @(posedge clk); #1; wait_cnt++;
    end
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    $display("[TB] %s: result=0x%04h ovf=%0b latency=%0d", tag, bus.out_result,
             bus.out_overflow, lat);
    check_eq({tag, "_result"}, 32'(bus.out_result), 32'(want_res));
    check_eq({tag, "_ovf"}, 32'(bus.out_overflow), 32'(want_ovf));
    check_eq({tag, "_lat"}, 32'(lat), 32'(want_lat));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", 32'(bus.out_result), 32'd0);
    check_eq("rst_ovf", 32'(bus.out_overflow), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(bus.in_ready), 32'd1);

    //      tag        sign  exp    {c,h,frac,g,s}                      result    ovf  lat
    run_op("one",      1'b0, 5'd15, {1'b0,1'b1,10'h000,1'b0,1'b0}, 16'h3C00, 1'b0, 3);
    run_op("carry",    1'b0, 5'd15, {1'b1,1'b0,10'h000,1'b0,1'b0}, 16'h4000, 1'b0, 4);
    run_op("lshift3",  1'b0, 5'd15, {1'b0,1'b0,10'h080,1'b0,1'b0}, 16'h3000, 1'b0, 6);
    run_op("tie_even", 1'b0, 5'd15, {1'b0,1'b1,10'h000,1'b1,1'b0}, 16'h3C00, 1'b0, 3);
    run_op("tie_odd",  1'b0, 5'd15, {1'b0,1'b1,10'h001,1'b1,1'b0}, 16'h3C02, 1'b0, 3);
    run_op("above",    1'b0, 5'd15, {1'b0,1'b1,10'h000,1'b1,1'b1}, 16'h3C01, 1'b0, 3);
    run_op("rnd_ovf",  1'b1, 5'd30, {1'b0,1'b1,10'h3FF,1'b1,1'b1}, 16'hFC00, 1'b1, 3);
    run_op("zero",     1'b1, 5'd15, 14'h0000,                      16'h0000, 1'b0, 2);
    run_op("subnorm",  1'b0, 5'd1,  {1'b0,1'b0,10'h200,1'b0,1'b0}, 16'h0200, 1'b0, 3);
    run_op("exp0",     1'b0, 5'd0,  {1'b0,1'b1,10'h000,1'b0,1'b0}, 16'h0400, 1'b0, 3);
    run_op("norm_ovf", 1'b0, 5'd30, {1'b1,1'b0,10'h000,1'b0,1'b0}, 16'h7C00, 1'b1, 4);
    run_op("sub_up",   1'b0, 5'd1,  {1'b0,1'b0,10'h3FF,1'b1,1'b1}, 16'h0400, 1'b0, 3);

    // Backpressure: result must hold and no new op may be accepted
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_exp   = 5'd15;
    bus.in_mant  = {1'b0, 1'b1, 10'h155, 1'b0, 1'b0};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_result", 32'(bus.out_result), 32'h0000BD55);
    held = bus.out_result;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("[TB] stall cycle %0d: result=0x%04h in_ready=%0b", i, bus.out_result, bus.in_ready);
      check_eq("bp_hold", 32'(bus.out_result), 32'(held));
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("bp_drop", 32'(bus.out_valid), 32'd0);

    // Reset pulse during NORM discards the op
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 5'd15;
    bus.in_mant  = {1'b0, 1'b0, 10'h080, 1'b0, 1'b0};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    $display("[TB] after mid-op reset: out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check_eq("mid_rst_no_result", 32'(bus.out_valid), 32'd0);

    run_op("after_rst", 1'b0, 5'd15, {1'b0,1'b1,10'h000,1'b0,1'b0}, 16'h3C00, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
